fifo_wr_arbiter: RTL and testbench

- Round-robin burst arbiter that shares the write port of async_fifo between NUM_REQ requesters.
- Runs entirely in the FIFO write-clock domain; its clk_i is the FIFO's wclk_i.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Gates writes with the FIFO full flag and aborts bursts that stall on full for too long.

---
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing the write port of async_fifo between
//   NUM_REQ requesters. Lives entirely in the FIFO write-clock domain.
//   A requester is granted for a burst of up to MAX_BURST words. Writes are
//   gated by the FIFO full flag, so a full FIFO is never written. A burst that
//   sits on full for STALL_LIMIT consecutive cycles is aborted.
//
// Ports
//   clk_i         write-domain clock (same net as the FIFO wclk_i)
//   rst_n_i       asynchronous active-low reset
//   req_i         per-requester "word available" level
//   last_i        per-requester "current word is the final word of its packet"
//   data_i        packed words; requester k owns bits [k*WIDTH +: WIDTH]
//   ack_o         word accepted this cycle (combinational, one-hot or zero)
//   gnt_o         registered one-hot grant
//   fifo_full_i   FIFO full_o
//   fifo_wr_en_o  FIFO wr_en_i (combinational)
//   fifo_wdata_o  FIFO wdata_i (granted requester's word, 0 when idle)
//   busy_o        high while a burst is in progress
//   abort_o       one-cycle pulse after a burst ends on stall timeout
module fifo_wr_arbiter #(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       last_i,
  input  logic [NUM_REQ*WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic                     busy_o,
  output logic                     abort_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_B   = 8'(MAX_BURST);
  localparam logic [7:0] STALL_L = 8'(STALL_LIMIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  logic [7:0]       beat_cnt;
  logic [7:0]       stall_cnt;

  // Saturating increment: counters stop at their limit instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + PTR_W'(1);
  endfunction

  // Round-robin scan: first set request at or above rr_ptr, wrapping at NUM_REQ.
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && req_i[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  logic       in_burst;
  logic       req_g;
  logic       last_g;
  logic       accept;
  logic       beat_hit;
  logic       stall_hit;
  logic       burst_done;

  assign in_burst = (state == BURST);
  assign req_g    = req_i[gidx];
  assign last_g   = last_i[gidx];

  // Full gates the accept directly, so a full FIFO can never be written.
  assign accept    = in_burst & req_g & ~fifo_full_i;
  assign beat_hit  = accept & (sat_inc(beat_cnt, MAX_B) == MAX_B);
  assign stall_hit = in_burst & req_g & fifo_full_i &
                     (sat_inc(stall_cnt, STALL_L) == STALL_L);

  // Exit on packet end, burst length, withdrawal, or stall timeout.
  assign burst_done = in_burst &
                      ((accept & (last_g | beat_hit)) | ~req_g | stall_hit);

  assign ack_o        = accept ? (NUM_REQ'(1) << gidx) : '0;
  assign fifo_wr_en_o = accept;
  assign fifo_wdata_o = in_burst ? data_i[int'(gidx)*WIDTH +: WIDTH] : '0;
  assign busy_o       = in_burst;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      abort_o   <= 1'b0;
    end else begin
      abort_o <= 1'b0;
      case (state)
        IDLE: begin
          // Arbitration cycle: grant is registered, nothing accepted yet.
          if (win_found) begin
            state     <= BURST;
            gidx      <= win_idx;
            gnt_o     <= NUM_REQ'(1) << win_idx;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt  <= sat_inc(beat_cnt, MAX_B);
            stall_cnt <= '0;
          end else if (req_g) begin
            // req high and not accepted means the FIFO is full
            stall_cnt <= sat_inc(stall_cnt, STALL_L);
          end
          // Going back to IDLE forces one bubble cycle between bursts.
          if (burst_done) begin
            state   <= IDLE;
            gnt_o   <= '0;
            rr_ptr  <= next_ptr(gidx);
            abort_o <= stall_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int SL = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [N*W-1:0] data = '0;
  logic           full = 1'b0;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           wr_en;
  logic [W-1:0]   wdata;
  logic           busy;
  logic           abort;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB), .STALL_LIMIT(SL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .last_i(last), .data_i(data),
    .ack_o(ack), .gnt_o(gnt), .fifo_full_i(full), .fifo_wr_en_o(wr_en),
    .fifo_wdata_o(wdata), .busy_o(busy), .abort_o(abort)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: whether a burst is open, who owns it, words and
  // full-stall cycles so far, the next round-robin start, and the abort pulse.
  bit m_busy = 0;
  bit m_abort = 0;
  int m_g = 0;
  int m_ptr = 0;
  int m_beats = 0;
  int m_stalls = 0;

  int cyc = 0;
  int writes = 0;
  int aborts = 0;
  int abort_cyc = -1;
  int grants[$];
  logic [N-1:0] prev_gnt = '0;
  int full_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    return 32'(1) << i;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_stalls = 0;
  endtask

  task automatic check_outputs();
    bit acc;
    acc = m_busy && req[m_g] && !full;
    chk("gnt",   32'(gnt),   m_busy ? onehot(m_g) : 32'd0);
    chk("ack",   32'(ack),   acc ? onehot(m_g) : 32'd0);
    chk("wr_en", 32'(wr_en), 32'(acc));
    chk("wdata", 32'(wdata), m_busy ? 32'(data[m_g*W +: W]) : 32'd0);
    chk("busy",  32'(busy),  32'(m_busy));
    chk("abort", 32'(abort), 32'(m_abort));
    chk("write_while_full", 32'(wr_en & full), 32'd0);
    if (wr_en === 1'b1) writes++;
    if (abort === 1'b1) begin aborts++; abort_cyc = cyc; end
    if (gnt !== '0 && prev_gnt === '0) begin
      for (int k = 0; k < N; k++) if (gnt[k]) grants.push_back(k);
    end
    prev_gnt = gnt;
  endtask

  // Spec-level rules applied once per rising edge.
  task automatic model_update();
    bit acc;
    bit fin;
    bit found;
    if (!m_busy) begin
      m_abort = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1;
          m_g = (m_ptr + k) % N;
        end
      end
      if (found) begin m_busy = 1; m_beats = 0; m_stalls = 0; end
    end else begin
      m_abort = 0;
      fin = 0;
      acc = req[m_g] && !full;
      if (acc) begin
        m_beats++;
        m_stalls = 0;
        if (last[m_g] || m_beats == MB) fin = 1;
      end else if (!req[m_g]) begin
        fin = 1;
      end else begin
        m_stalls++;
        if (m_stalls == SL) begin fin = 1; m_abort = 1; end
      end
      if (fin) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
    req = r; last = l; full = f; data = $urandom;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    // Reset state
    drive(4'b1111, 4'b0000, 1'b0);
    #2;
    chk("rst_gnt",   32'(gnt),   0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_ack",   32'(ack),   0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_abort", 32'(abort), 0);
    req = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Grant order with everyone requesting
    grants.delete(); writes = 0;
    repeat (25) begin drive(4'b1111, 4'b0000, 1'b0); step(); end
    chk("order_count", 32'(grants.size()), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("order_idx", 32'(grants[i]), 32'(i % N));
    chk("order_writes", 32'(writes), 20);

    // No requests: stay idle
    repeat (3) begin drive(4'b0000, 4'b0000, 1'b0); step(); end

    // Early termination on last_i, then re-grant to the same requester
    writes = 0;
    repeat (3) begin
      drive(4'b0100, (m_busy && m_beats == 1) ? 4'b0100 : 4'b0000, 1'b0);
      step();
    end
    chk("early_writes", 32'(writes), 2);
    chk("early_idle", 32'(busy), 0);
    drive(4'b0100, 4'b0000, 1'b0); step();
    chk("regrant_2", 32'(gnt), 32'b0100);
    drive(4'b0000, 4'b0000, 1'b0); step();
    step();

    // Full gating mid-burst
    writes = 0; aborts = 0;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0001, 4'b0000, (i >= 3 && i <= 7)); step();
    end
    chk("gate_writes", 32'(writes), 4);
    chk("gate_aborts", 32'(aborts), 0);
    chk("gate_idle", 32'(busy), 0);

    // Stall abort after grant to requester 1
    writes = 0; aborts = 0; abort_cyc = -1; start = cyc;
    for (int i = 0; i < 21; i++) begin drive(4'b0110, 4'b0000, 1'b1); step(); end
    chk("abort_cycle", 32'(abort_cyc - start), 17);
    chk("abort_count", 32'(aborts), 1);
    chk("stall_writes", 32'(writes), 0);
    chk("after_abort_gnt", 32'(gnt), 32'b0100);
    repeat (4) begin drive(4'b0110, 4'b0000, 1'b0); step(); end
    chk("after_abort_writes", 32'(writes), 4);
    drive(4'b0000, 4'b0000, 1'b0); step();

    // Withdrawal by requester 3 after one word
    writes = 0;
    drive(4'b1000, 4'b0000, 1'b0); step();
    drive(4'b1000, 4'b0000, 1'b0); step();
    drive(4'b0000, 4'b0000, 1'b0); step();
    chk("withdraw_writes", 32'(writes), 1);
    chk("withdraw_idle", 32'(busy), 0);
    drive(4'b0011, 4'b0000, 1'b0); step();
    chk("rr_after_withdraw", 32'(gnt), 32'b0001);
    drive(4'b0000, 4'b0000, 1'b0); step();

    // Randomized traffic
    repeat (400) begin
      logic f;
      if (full_run > 0) begin
        f = 1'b1; full_run--;
      end else begin
        f = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 39) == 0) full_run = 18;
      end
      drive(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, f);
      step();
    end

    // Asynchronous reset mid-burst
    drive(4'b0000, 4'b0000, 1'b0); step();
    drive(4'b1111, 4'b0000, 1'b0); step();
    drive(4'b1111, 4'b0000, 1'b0); step();
    chk("pre_reset_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt",   32'(gnt),   0);
    chk("arst_busy",  32'(busy),  0);
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_wdata", 32'(wdata), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0); step();
    chk("post_reset_grant", 32'(gnt), 32'b0001);
    repeat (6) begin drive(4'b1111, 4'b0000, 1'b0); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
